// File: rtl/flop_cell_bank.sv
// flop_cell_bank: two independent flop banks sharing one clock.
//   Bank A: plain D flip-flop with synchronous reset to A_RESET_VAL.
//   Bank B: D flip-flop with a per-bit level-sensitive asynchronous set that
//           forces B_SET_VAL[i], plus synchronous reset to B_RESET_VAL.
// Used as the leaf cell of reset synchronisers, glitch latches and reset
// stretchers, so each bit maps onto exactly one library flop.
module flop_cell_bank #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] A_RESET_VAL = '0,
  parameter logic [WIDTH-1:0] B_RESET_VAL = '0,
  parameter logic [WIDTH-1:0] B_SET_VAL   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_a,
  output logic [WIDTH-1:0] q_a,
  input  logic [WIDTH-1:0] set_b,
  input  logic [WIDTH-1:0] d_b,
  output logic [WIDTH-1:0] q_b
);

  // Bank A: one-cycle register, synchronous reset has priority over data.
  always_ff @(posedge clk) begin
    if (rst) q_a <= A_RESET_VAL;
    else     q_a <= d_a;
  end

  // Bank B is built bit by bit: each bit owns its own asynchronous control so
  // a set on one bit never disturbs another, and the forced polarity decides
  // whether the bit maps to an async-set or an async-reset flop.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bank_b
    logic q_bit;

    if (B_SET_VAL[i]) begin : g_aset
      // Async-set flop: set wins over rst and d_b, even when it spans an edge.
      always_ff @(posedge clk or posedge set_b[i]) begin
        if (set_b[i])  q_bit <= 1'b1;
        else if (rst)  q_bit <= B_RESET_VAL[i];
        else           q_bit <= d_b[i];
      end
    end else begin : g_areset
      // Forced value is 0, so the same behaviour is an async-reset flop.
      always_ff @(posedge clk or posedge set_b[i]) begin
        if (set_b[i])  q_bit <= 1'b0;
        else if (rst)  q_bit <= B_RESET_VAL[i];
        else           q_bit <= d_b[i];
      end
    end

    assign q_b[i] = q_bit;
  end

endmodule

// File: tb/tb_flop_cell_bank.sv
`timescale 1ns/100ps
module tb_flop_cell_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d_a, d_b, set_b;
  logic [3:0] q_a, q_b;

  logic chain_rst, chain_set;
  logic s1, s2, s3, reset_out;
  logic c1_qa, c2_qa, c3_qb, c4_qb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  flop_cell_bank #(
    .WIDTH(4), .A_RESET_VAL(4'b0101), .B_RESET_VAL(4'b0000), .B_SET_VAL(4'b1010)
  ) dut (
    .clk(clk), .rst(rst), .d_a(d_a), .q_a(q_a),
    .set_b(set_b), .d_b(d_b), .q_b(q_b)
  );

  // four-stage reset stretcher: async-set, async-set, dff, dff
  flop_cell_bank u_c1 (.clk(clk), .rst(chain_rst), .d_a(1'b0), .q_a(c1_qa),
                       .set_b(chain_set), .d_b(1'b0), .q_b(s1));
  flop_cell_bank u_c2 (.clk(clk), .rst(chain_rst), .d_a(1'b0), .q_a(c2_qa),
                       .set_b(chain_set), .d_b(s1), .q_b(s2));
  flop_cell_bank u_c3 (.clk(clk), .rst(chain_rst), .d_a(s2), .q_a(s3),
                       .set_b(1'b0), .d_b(1'b0), .q_b(c3_qb));
  flop_cell_bank u_c4 (.clk(clk), .rst(chain_rst), .d_a(s3), .q_a(reset_out),
                       .set_b(1'b0), .d_b(1'b0), .q_b(c4_qb));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; d_a = 4'b1111; d_b = 4'b1111; set_b = 4'b0000;
    chain_rst = 1'b1; chain_set = 1'b0;
    edge_sample();
    edge_sample();
    chk("a_reset", q_a, 4'b0101);
    chk("b_reset", q_b, 4'b0000);
    chk("chain_reset", {s1, s2, s3, reset_out}, 4'b0000);

    // bank A pipeline, no mid-cycle change
    @(negedge clk);
    rst = 1'b0; chain_rst = 1'b0; d_a = 4'b1010;
    #1;
    chk("a_hold_midcycle", q_a, 4'b0101);
    chk("b_hold_midcycle", q_b, 4'b0000);
    edge_sample();
    chk("a_data_1010", q_a, 4'b1010);
    chk("b_data_1111", q_b, 4'b1111);
    @(negedge clk);
    d_a = 4'b0000; d_b = 4'b0000;
    edge_sample();
    chk("a_data_0000", q_a, 4'b0000);
    chk("b_data_0000", q_b, 4'b0000);

    // 1 ns set glitch between edges
    @(negedge clk);
    #2;
    set_b = 4'b0011;
    #0.5;
    chk("b_set_immediate", q_b, 4'b0010);
    #0.5;
    set_b = 4'b0000;
    #1;
    chk("b_set_captured", q_b, 4'b0010);
    edge_sample();
    chk("b_after_glitch_edge", q_b, 4'b0000);
    chk("a_unaffected", q_a, 4'b0000);

    // bits 2-3 follow d_b while bits 0-1 are forced
    @(negedge clk);
    set_b = 4'b0011; d_b = 4'b1100;
    #1;
    chk("multibit_immediate", q_b, 4'b0010);
    edge_sample();
    chk("multibit_edge", q_b, 4'b1110);

    // set held across edges with rst high
    @(negedge clk);
    d_b = 4'b0000; rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      edge_sample();
      chk($sformatf("set_held_edge%0d", n), q_b, 4'b0010);
    end
    chk("a_reset_again", q_a, 4'b0101);

    // release with rst high: reset value, not d_b
    @(negedge clk);
    set_b = 4'b0000; d_b = 4'b1111;
    #1;
    chk("release_hold", q_b, 4'b0010);
    edge_sample();
    chk("release_rst_edge", q_b, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    edge_sample();
    chk("release_data_edge", q_b, 4'b1111);

    // set on bits 3 (forces 1) and 2 (forces 0)
    @(negedge clk);
    set_b = 4'b1100; d_b = 4'b0101;
    #1;
    chk("upper_set", q_b, 4'b1011);
    edge_sample();
    chk("upper_set_edge", q_b, 4'b1001);
    @(negedge clk);
    set_b = 4'b0000;
    edge_sample();
    chk("upper_release", q_b, 4'b0101);

    // reset stretcher chain
    @(negedge clk);
    #2;
    chain_set = 1'b1;
    #1;
    chain_set = 1'b0;
    #0.5;
    chk("chain_glitch", {s1, s2, s3, reset_out}, 4'b1100);
    begin
      logic [4:0] exp_out;
      exp_out = 5'b00110;  // reset_out after edges 1..5, edge 1 at bit 0
      for (int n = 0; n < 5; n++) begin
        edge_sample();
        chk($sformatf("chain_edge%0d", n + 1), {3'b000, reset_out}, {3'b000, exp_out[n]});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
